// File: rtl/mps_clk_pkg.sv
// Shared types, constants and helpers for the multi-channel divided-clock generator.
package mps_clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } chan_state_t;

    localparam int unsigned MIN_DIV = 32'd2;

    // Length of the high phase of an N-cycle period.
    function automatic int unsigned half(input int unsigned n);
        return n >> 32'd1;
    endfunction

endpackage

// File: rtl/mps_clk_chan.sv
// One divided-clock channel: IDLE/ARMED/RUN control, period counter,
// pending ratio/stop requests applied only at a period boundary.
module mps_clk_chan #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             wr,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             start,
    output logic             clk_out,
    output logic             clk_stb,
    output logic             ch_run
);
    import mps_clk_pkg::*;

    localparam logic [DIV_W-1:0] ZERO_C = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] RST_DIV_C = DIV_W'(MIN_DIV);

    chan_state_t      state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cur_div_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             pend_div_v_r;
    logic             pend_stop_r;
    logic             clk_out_r;
    logic             clk_stb_r;
    logic             ch_run_r;

    logic [DIV_W-1:0] cnt_inc_s;
    logic [DIV_W-1:0] half_s;
    logic [DIV_W-1:0] next_div_s;
    logic             wrap_s;
    logic             stop_s;
    logic             clk_hi_s;

    // Period wrap detection; a write landing on the wrap edge still counts for this wrap.
    always_comb begin
        cnt_inc_s = cnt_r + ONE_C;
        half_s    = DIV_W'(half(32'(cur_div_r)));
        wrap_s    = (cnt_r == (cur_div_r - ONE_C));
        clk_hi_s  = (cnt_inc_s < half_s);
        stop_s    = pend_stop_r | (wr & ~wr_en);
        if (wr && wr_en) begin
            next_div_s = wr_div;
        end else if (pend_div_v_r) begin
            next_div_s = pend_div_r;
        end else begin
            next_div_s = cur_div_r;
        end
    end

    // Channel state machine with registered clock, strobe and run outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO_C;
            cur_div_r    <= RST_DIV_C;
            pend_div_r   <= RST_DIV_C;
            pend_div_v_r <= 1'b0;
            pend_stop_r  <= 1'b0;
            clk_out_r    <= 1'b0;
            clk_stb_r    <= 1'b0;
            ch_run_r     <= 1'b0;
        end else if (srst) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO_C;
            cur_div_r    <= RST_DIV_C;
            pend_div_r   <= RST_DIV_C;
            pend_div_v_r <= 1'b0;
            pend_stop_r  <= 1'b0;
            clk_out_r    <= 1'b0;
            clk_stb_r    <= 1'b0;
            ch_run_r     <= 1'b0;
        end else begin
            clk_stb_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_out_r <= 1'b0;
                    ch_run_r  <= 1'b0;
                    if (wr && wr_en) begin
                        cur_div_r <= wr_div;
                        state_r   <= ARMED;
                    end
                end
                ARMED: begin
                    if (start) begin
                        state_r   <= RUN;
                        cnt_r     <= ZERO_C;
                        clk_out_r <= 1'b1;
                        clk_stb_r <= 1'b1;
                        ch_run_r  <= 1'b1;
                        // A write on the start edge behaves like a RUN-state write.
                        if (wr && wr_en) begin
                            pend_div_r   <= wr_div;
                            pend_div_v_r <= 1'b1;
                        end else if (wr) begin
                            pend_stop_r <= 1'b1;
                        end
                    end else if (wr && wr_en) begin
                        cur_div_r <= wr_div;
                    end else if (wr) begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (wrap_s) begin
                        cnt_r        <= ZERO_C;
                        pend_div_v_r <= 1'b0;
                        pend_stop_r  <= 1'b0;
                        if (stop_s) begin
                            state_r   <= IDLE;
                            clk_out_r <= 1'b0;
                            ch_run_r  <= 1'b0;
                        end else begin
                            cur_div_r <= next_div_s;
                            clk_out_r <= 1'b1;
                            clk_stb_r <= 1'b1;
                        end
                    end else begin
                        cnt_r     <= cnt_inc_s;
                        clk_out_r <= clk_hi_s;
                        if (wr && wr_en) begin
                            pend_div_r   <= wr_div;
                            pend_div_v_r <= 1'b1;
                        end else if (wr) begin
                            pend_stop_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_out_r <= 1'b0;
                    ch_run_r  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out = clk_out_r;
    assign clk_stb = clk_stb_r;
    assign ch_run  = ch_run_r;

endmodule

// File: rtl/mps_clk_gen.sv
// Runtime-programmable divided-clock generator: validates configuration writes,
// routes them to the addressed channel and starts all armed channels together.
module mps_clk_gen #(
    parameter int NCH   = 3,
    parameter int DIV_W = 8,
    parameter int CH_W  = (NCH > 32'sd1) ? $clog2(NCH) : 32'sd1
) (
    input  logic             systemclk,
    input  logic             sys_reset,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             sync_start,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   clk_stb,
    output logic [NCH-1:0]   ch_run,
    output logic             cfg_ack,
    output logic             cfg_err
);
    import mps_clk_pkg::*;

    logic           ch_ok_s;
    logic           div_ok_s;
    logic           accept_s;
    logic           reject_s;
    logic           srst_s;
    logic [NCH-1:0] wr_sel_s;
    logic           cfg_ack_r;
    logic           cfg_err_r;

    // Out-of-range channels and sub-minimum ratios are rejected; stop requests ignore the ratio.
    always_comb begin
        ch_ok_s  = (32'(cfg_ch) < 32'(NCH));
        div_ok_s = !cfg_en || (32'(cfg_div) >= MIN_DIV);
        accept_s = cfg_wr && ch_ok_s && div_ok_s;
        reject_s = cfg_wr && !accept_s;
        srst_s   = 1'b0;
    end

    // Write handshake pulses, one cycle after the write is sampled.
    always_ff @(posedge systemclk or negedge sys_reset) begin
        if (!sys_reset) begin
            cfg_ack_r <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_ack_r <= accept_s;
            cfg_err_r <= reject_s;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign wr_sel_s[g] = accept_s && (cfg_ch == CH_W'(g));

        mps_clk_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk     (systemclk),
            .rst_n   (sys_reset),
            .srst    (srst_s),
            .wr      (wr_sel_s[g]),
            .wr_en   (cfg_en),
            .wr_div  (cfg_div),
            .start   (sync_start),
            .clk_out (clk_out[g]),
            .clk_stb (clk_stb[g]),
            .ch_run  (ch_run[g])
        );
    end

    assign cfg_ack = cfg_ack_r;
    assign cfg_err = cfg_err_r;

endmodule
